// File: rtl/pb_event_detect.sv
// pb_event_detect: multi-channel pushbutton front end.
// Per channel: 2-flop synchroniser -> debouncer -> pressed/released/long_press
// one-cycle event pulses. Channels are independent; only clk and rst_n are shared.
// Optional build macro PB_LONG_REPEAT_EN: when defined, long_press auto-repeats
// every LONG_CYC cycles while held; when undefined it fires once per press.
module pb_event_detect #(
    parameter int N_CH       = 4,
    parameter int DEB_CYC    = 16,
    parameter int LONG_CYC   = 1024,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pb,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] released,
    output logic [N_CH-1:0] long_press
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int HW = $clog2(LONG_CYC + 1);

    // Count value at which one more disagreeing sample accepts the new level.
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    // Count value at which one more held cycle completes a long-press period.
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
    // Raw pin value meaning "not pressed"; synchroniser resets to it so that
    // reset release never looks like an edge.
    localparam logic IDLE_RAW = ACTIVE_LOW ? 1'b1 : 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic          sync_a_reg;
            logic          sync_b_reg;
            logic          sample;
            logic [DW-1:0] deb_cnt_reg;
            logic [DW-1:0] deb_cnt_next;
            logic          level_reg;
            logic          level_next;
            logic          level_d_reg;
            logic [HW-1:0] hold_cnt_reg;
            logic [HW-1:0] hold_cnt_next;
            logic          hold_fire;
            logic          pressed_reg;
            logic          released_reg;
            logic          long_reg;

            // Two-flop synchroniser on the raw asynchronous pin.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_a_reg <= IDLE_RAW;
                    sync_b_reg <= IDLE_RAW;
                end else begin
                    sync_a_reg <= pb[gi];
                    sync_b_reg <= sync_a_reg;
                end
            end

            // Normalise polarity: 1 always means pressed from here on.
            assign sample = ACTIVE_LOW ? ~sync_b_reg : sync_b_reg;

            // Debouncer: count consecutive disagreeing samples; any agreeing
            // sample restarts the count, reaching DEB_CYC flips the level.
            always_comb begin
                deb_cnt_next = '0;
                level_next   = level_reg;
                if (sample != level_reg) begin
                    if (deb_cnt_reg == DEB_LAST) begin
                        level_next = ~level_reg;
                    end else begin
                        deb_cnt_next = deb_cnt_reg + 1'b1;
                    end
                end
            end

            // Hold counter: starts counting from the cycle the pressed pulse is
            // shown and only advances if the level survives this edge, so a
            // release landing on the completing edge suppresses long_press.
            always_comb begin
                hold_cnt_next = '0;
                hold_fire     = 1'b0;
                if (level_reg && level_d_reg && level_next) begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        hold_fire = 1'b1;
`ifdef PB_LONG_REPEAT_EN
                        hold_cnt_next = '0;
`else
                        hold_cnt_next = HOLD_MAX;
`endif
                    end else if (hold_cnt_reg == HOLD_MAX) begin
                        hold_cnt_next = HOLD_MAX;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                    end
                end
            end

            // Channel state and registered one-cycle event pulses.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    deb_cnt_reg  <= '0;
                    level_reg    <= 1'b0;
                    level_d_reg  <= 1'b0;
                    hold_cnt_reg <= '0;
                    pressed_reg  <= 1'b0;
                    released_reg <= 1'b0;
                    long_reg     <= 1'b0;
                end else begin
                    deb_cnt_reg  <= deb_cnt_next;
                    level_reg    <= level_next;
                    level_d_reg  <= level_reg;
                    hold_cnt_reg <= hold_cnt_next;
                    pressed_reg  <= level_reg & ~level_d_reg;
                    released_reg <= ~level_reg & level_d_reg;
                    long_reg     <= hold_fire;
                end
            end

            assign level[gi]      = level_reg;
            assign pressed[gi]    = pressed_reg;
            assign released[gi]   = released_reg;
            assign long_press[gi] = long_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pb_event_detect.sv
// Testbench for pb_event_detect (N_CH=2, DEB_CYC=4, LONG_CYC=20, ACTIVE_LOW=1).
// A per-edge behavioural model derives expected outputs from raw input history;
// directed scenarios add hand-computed timing checks.
`timescale 1ns/1ps
module tb_pb_event_detect;

    localparam int N_CH     = 2;
    localparam int DEB_CYC  = 4;
    localparam int LONG_CYC = 20;
    localparam bit ACTIVE_LOW = 1'b1;
`ifdef PB_LONG_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif
    localparam int NEVER = -100000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] pb = 2'b11;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] pressed;
    logic [N_CH-1:0] released;
    logic [N_CH-1:0] long_press;

    pb_event_detect #(
        .N_CH(N_CH), .DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pb(pb), .level(level),
        .pressed(pressed), .released(released), .long_press(long_press)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int edge_no = -1;

    initial forever begin
        @(posedge clk);
        edge_no++;
    end

    task automatic cmp(input string name, input logic [N_CH-1:0] act,
                       input logic [N_CH-1:0] exp, input int tt);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%b want=%b", name, tt, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N_CH-1:0] cap_hist [0:4095];   // pressed-normalised raw value per edge
    int              rst_last = 0;        // last edge at/after which reset held state
    bit              m_level  [N_CH];
    int              rise_e   [N_CH];
    int              fall_e   [N_CH];
    int              tog_e    [N_CH];
    logic [N_CH-1:0] exp_level, exp_pressed, exp_released, exp_long;
    logic [N_CH-1:0] in_pb_l = 2'b11;
    logic            in_rst_l = 1'b0;

    // observations
    int press_cnt [N_CH];
    int rel_cnt   [N_CH];
    int long_cnt  [N_CH];
    int press_e   [N_CH];
    int rel_e     [N_CH];
    int long_q[$];

    // Debouncer sees the value captured two edges earlier, unless reset
    // touched either synchroniser stage since then.
    function automatic bit samp(input int ch, input int tt);
        if (tt - 2 <= rst_last) return 1'b0;
        return cap_hist[(tt - 2) % 4096][ch];
    endfunction

    task automatic model_reset(input int tt);
        rst_last = tt;
        for (int ch = 0; ch < N_CH; ch++) begin
            m_level[ch] = 1'b0;
            rise_e[ch]  = NEVER;
            fall_e[ch]  = NEVER;
            tog_e[ch]   = NEVER;
        end
        exp_level    = '0;
        exp_pressed  = '0;
        exp_released = '0;
        exp_long     = '0;
    endtask

    initial begin
        int  t;
        int  start;
        int  d;
        bit  all_diff;
        for (int ch = 0; ch < N_CH; ch++) begin
            press_cnt[ch] = 0; rel_cnt[ch] = 0; long_cnt[ch] = 0;
            press_e[ch] = NEVER; rel_e[ch] = NEVER;
        end
        model_reset(0);
        forever begin
            @(negedge clk);
            t = edge_no;
            if (!in_rst_l) begin
                model_reset(t);
            end else begin
                cap_hist[t % 4096] = ~in_pb_l;
                for (int ch = 0; ch < N_CH; ch++) begin
                    // level flips once DEB_CYC successive samples since the last
                    // flip/reset all disagree with it
                    start = (tog_e[ch] > rst_last) ? tog_e[ch] : rst_last;
                    all_diff = (t - start >= DEB_CYC);
                    for (int j = 0; j < DEB_CYC; j++)
                        if (samp(ch, t - j) == m_level[ch]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_level[ch] = ~m_level[ch];
                        tog_e[ch] = t;
                        if (m_level[ch]) rise_e[ch] = t;
                        else             fall_e[ch] = t;
                    end
                    exp_level[ch]    = m_level[ch];
                    exp_pressed[ch]  = (rise_e[ch] == t - 1);
                    exp_released[ch] = (fall_e[ch] == t - 1);
                    // long_press: LONG_CYC multiples after the pressed pulse,
                    // with the level still held after this edge
                    d = t - (rise_e[ch] + 1);
                    exp_long[ch] = m_level[ch] && (d > 0) && (d % LONG_CYC == 0)
                                   && (REPEAT || d == LONG_CYC);
                end
            end
            in_pb_l  = pb;
            in_rst_l = rst_n;
            if (!rst_n) model_reset(t);

            cmp("level",      level,      exp_level,    t);
            cmp("pressed",    pressed,    exp_pressed,  t);
            cmp("released",   released,   exp_released, t);
            cmp("long_press", long_press, exp_long,     t);

            for (int ch = 0; ch < N_CH; ch++) begin
                if (pressed[ch] === 1'b1)  begin press_cnt[ch]++; press_e[ch] = t; end
                if (released[ch] === 1'b1) begin rel_cnt[ch]++;   rel_e[ch] = t;   end
                if (long_press[ch] === 1'b1) begin
                    long_cnt[ch]++;
                    if (ch == 1) long_q.push_back(t);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [N_CH-1:0] p, input logic r);
        @(posedge clk);
        #2;
        pb    = p;
        rst_n = r;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int e0;
        rst_n = 1'b0;
        pb    = 2'b11;

        // reset, then 50 quiet cycles
        idle(5);
        drive(2'b11, 1'b1);
        idle(50);
        chk_int("reset_events", press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1]
                + long_cnt[0] + long_cnt[1], 0);
        @(negedge clk);
        cmp("reset_level", level, 2'b00, edge_no);

        // glitch: 3 captured low samples on ch0
        drive(2'b10, 1'b1);
        idle(2);
        drive(2'b11, 1'b1);
        idle(15);
        chk_int("glitch_press", press_cnt[0], 0);
        chk_int("glitch_release", rel_cnt[0], 0);

        // clean press / release on ch0
        drive(2'b10, 1'b1);
        e0 = edge_no + 1;
        idle(10);
        chk_int("press0_edge", press_e[0], e0 + 6);
        chk_int("press0_count", press_cnt[0], 1);
        @(negedge clk);
        cmp("press0_level", level, 2'b01, edge_no);
        drive(2'b11, 1'b1);
        e0 = edge_no + 1;
        idle(10);
        chk_int("release0_edge", rel_e[0], e0 + 6);
        chk_int("release0_count", rel_cnt[0], 1);

        // long press on ch1: 80 captured low samples
        long_q.delete();
        drive(2'b01, 1'b1);
        e0 = edge_no + 1;
        idle(79);
        drive(2'b11, 1'b1);
        idle(20);
        chk_int("long_press1_edge", press_e[1], e0 + 6);
        chk_int("long_count", long_q.size(), REPEAT ? 3 : 1);
        chk_int("long_first", (long_q.size() > 0) ? long_q[0] : -1, e0 + 26);
        chk_int("long_last", (long_q.size() > 0) ? long_q[long_q.size() - 1] : -1,
                REPEAT ? e0 + 66 : e0 + 26);
        chk_int("long_release_edge", rel_e[1], e0 + 86);

        // short hold: release captured 15 edges after pressed
        long_q.delete();
        drive(2'b01, 1'b1);
        e0 = edge_no + 1;
        idle(20);
        drive(2'b11, 1'b1);
        idle(20);
        chk_int("short_press_edge", press_e[1], e0 + 6);
        chk_int("short_long_count", long_q.size(), 0);
        chk_int("short_release_edge", rel_e[1], e0 + 27);

        // simultaneous press on both channels
        drive(2'b00, 1'b1);
        e0 = edge_no + 1;
        idle(10);
        chk_int("sim_press0_edge", press_e[0], e0 + 6);
        chk_int("sim_press1_edge", press_e[1], e0 + 6);

        // reset mid-hold, then release reset with buttons still held
        drive(2'b00, 1'b0);
        @(negedge clk);
        cmp("midreset_level", level, 2'b00, edge_no);
        idle(2);
        drive(2'b00, 1'b1);
        e0 = edge_no + 1;
        idle(10);
        chk_int("repress0_edge", press_e[0], e0 + 6);
        chk_int("repress1_edge", press_e[1], e0 + 6);
        chk_int("press0_total", press_cnt[0], 3);
        chk_int("press1_total", press_cnt[1], 4);

        drive(2'b11, 1'b1);
        idle(15);
        chk_int("final_release0", rel_cnt[0], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
